// File: rtl/cplx_mac_if.sv
// Operand/result handshake bundle for cplx_mac_pipe.
// The master drives operands and consumes results; the slave is the datapath.
interface cplx_mac_if #(
   parameter int SIZE  = 16,
   parameter int GUARD = 4
);
   localparam int RW = SIZE + 1 + GUARD;

   logic [SIZE-1:0]   a;
   logic [SIZE-1:0]   b;
   logic              a_valid;
   logic              b_valid;
   logic              in_last;
   logic [1:0]        mode;
   logic              in_ready;
   logic [2*RW-1:0]   result;
   logic              valid;
   logic              out_ready;

   modport master (
      output a, b, a_valid, b_valid, in_last, mode, out_ready,
      input  in_ready, result, valid
   );

   modport slave (
      input  a, b, a_valid, b_valid, in_last, mode, out_ready,
      output in_ready, result, valid
   );
endinterface

// File: rtl/cplx_mac_pipe.sv
// Three-stage signed complex multiplier / multiply-accumulator with valid/ready
// flow control: operand register, four partial products, combine + accumulate.
module cplx_mac_pipe #(
   parameter int SIZE  = 16,
   parameter int GUARD = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   cplx_mac_if.slave  bus
);
   localparam int H     = SIZE / 2;
   localparam int RW    = SIZE + 1 + GUARD;
   localparam int NPROD = 4;

   typedef struct packed {
      logic [H-1:0] ar;
      logic [H-1:0] ai;
      logic [H-1:0] br;
      logic [H-1:0] bi;
      logic         conj;
      logic         mac;
      logic         last;
   } beat_t;

   // p[0]=ar*br, p[1]=ai*bi, p[2]=ar*bi, p[3]=ai*br
   typedef struct packed {
      logic [NPROD-1:0][SIZE-1:0] p;
      logic                       conj;
      logic                       mac;
      logic                       last;
   } prod_t;

   logic                       stall;
   logic                       accept;
   logic [2:1]                 vld_pipe;
   beat_t                      s1, s1_d;
   prod_t                      s2, s2_d;
   logic [NPROD-1:0][SIZE-1:0] prod_d;
   logic [RW-1:0]              acc_re, acc_im;
   logic [RW-1:0]              re, im, sum_re, sum_im;
   logic                       valid_q;
   logic [2*RW-1:0]            result_q;

   assign stall        = valid_q & ~bus.out_ready;
   assign bus.in_ready = ~stall;
   assign accept       = bus.a_valid & bus.b_valid & ~stall;
   assign bus.valid    = valid_q;
   assign bus.result   = result_q;

   assign s1_d = '{
      ar:   bus.a[H-1:0],
      ai:   bus.a[SIZE-1:H],
      br:   bus.b[H-1:0],
      bi:   bus.b[SIZE-1:H],
      conj: bus.mode[0],
      mac:  bus.mode[1],
      last: bus.in_last
   };

   // Each product of two H-bit signed values fits exactly in SIZE signed bits.
   for (genvar k = 0; k < NPROD; k++) begin : g_prod
      localparam bit USE_AI = (k == 1) || (k == 3);
      localparam bit USE_BI = (k == 1) || (k == 2);
      logic [H-1:0]    xs, ys;
      logic [SIZE-1:0] xe, ye;
      assign xs        = USE_AI ? s1.ai : s1.ar;
      assign ys        = USE_BI ? s1.bi : s1.br;
      assign xe        = {{H{xs[H-1]}}, xs};
      assign ye        = {{H{ys[H-1]}}, ys};
      assign prod_d[k] = $signed(xe) * $signed(ye);
   end

   assign s2_d = '{p: prod_d, conj: s1.conj, mac: s1.mac, last: s1.last};

   function automatic logic [RW-1:0] sx(input logic [SIZE-1:0] v);
      return {{(RW-SIZE){v[SIZE-1]}}, v};
   endfunction

   // Two's-complement add/sub at RW bits: accumulation wraps, never saturates.
   always_comb begin
      re     = '0;
      im     = '0;
      if (s2.conj) begin
         re = sx(s2.p[0]) + sx(s2.p[1]);
         im = sx(s2.p[3]) - sx(s2.p[2]);
      end else begin
         re = sx(s2.p[0]) - sx(s2.p[1]);
         im = sx(s2.p[2]) + sx(s2.p[3]);
      end
      sum_re = acc_re + re;
      sum_im = acc_im + im;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         s1       <= '0;
         s2       <= '0;
         acc_re   <= '0;
         acc_im   <= '0;
         valid_q  <= 1'b0;
         result_q <= '0;
      end else if (!stall) begin
         vld_pipe <= {vld_pipe[1], accept};
         if (accept)      s1 <= s1_d;
         if (vld_pipe[1]) s2 <= s2_d;
         valid_q <= 1'b0;
         if (vld_pipe[2]) begin
            if (!s2.mac) begin
               valid_q  <= 1'b1;
               result_q <= {im, re};
            end else if (s2.last) begin
               valid_q  <= 1'b1;
               result_q <= {sum_im, sum_re};
               acc_re   <= '0;
               acc_im   <= '0;
            end else begin
               acc_re   <= sum_re;
               acc_im   <= sum_im;
            end
         end
      end
   end
endmodule

// File: tb/tb_cplx_mac_pipe.sv
// Directed bench for cplx_mac_pipe: hand-computed complex products and MAC sums.
module tb_cplx_mac_pipe;
   localparam int SIZE  = 16;
   localparam int GUARD = 4;
   localparam int RW    = SIZE + 1 + GUARD;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;

   cplx_mac_if #(.SIZE(SIZE), .GUARD(GUARD)) bus();

   cplx_mac_pipe #(.SIZE(SIZE), .GUARD(GUARD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic signed [RW-1:0] re_of(input logic [2*RW-1:0] r);
      return r[RW-1:0];
   endfunction

   function automatic logic signed [RW-1:0] im_of(input logic [2*RW-1:0] r);
      return r[2*RW-1:RW];
   endfunction

   // Present inputs for one cycle, then step to just after the next rising edge.
   task automatic drive(input logic av, input logic bv, input logic [SIZE-1:0] a,
                        input logic [SIZE-1:0] b, input logic [1:0] m, input logic last);
      bus.a_valid = av;
      bus.b_valid = bv;
      bus.a       = a;
      bus.b       = b;
      bus.mode    = m;
      bus.in_last = last;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, '0, '0, 2'd0, 1'b0);
   endtask

   task automatic test_reset();
      bus.a_valid   = 1'b0;
      bus.b_valid   = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.mode      = 2'd0;
      bus.in_last   = 1'b0;
      bus.out_ready = 1'b1;
      rst_n         = 1'b0;
      #3;
      checks++;
      if (bus.valid !== 1'b0) begin
         errors++; $display("FAIL reset_valid got %b expected 0", bus.valid);
      end
      checks++;
      if (bus.result !== '0) begin
         errors++; $display("FAIL reset_result got %h expected 0", bus.result);
      end
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++; $display("FAIL reset_in_ready got %b expected 1", bus.in_ready);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_product(input string name, input logic [SIZE-1:0] a,
                               input logic [SIZE-1:0] b, input logic [1:0] m,
                               input int er, input int ei);
      logic signed [RW-1:0] xr, xi;
      xr = er[RW-1:0];
      xi = ei[RW-1:0];
      drive(1'b1, 1'b1, a, b, m, 1'b0);
      idle();
      checks++;
      if (bus.valid !== 1'b0) begin
         errors++; $display("FAIL %s_early_valid got %b expected 0", name, bus.valid);
      end
      idle();
      checks++;
      if (bus.valid !== 1'b1 || re_of(bus.result) !== xr || im_of(bus.result) !== xi) begin
         errors++;
         $display("FAIL %s got valid=%b re=%0d im=%0d expected valid=1 re=%0d im=%0d",
                  name, bus.valid, re_of(bus.result), im_of(bus.result), xr, xi);
      end
      idle();
      checks++;
      if (bus.valid !== 1'b0) begin
         errors++; $display("FAIL %s_one_cycle got valid=%b expected 0", name, bus.valid);
      end
   endtask

   task automatic test_mac_group();
      int n;
      logic [2*RW-1:0] r;
      n = 0; r = '0;
      for (int i = 0; i < 8; i++) begin
         if (i < 4) drive(1'b1, 1'b1, 16'h0101, 16'h0101, 2'd2, i == 3);
         else idle();
         if (bus.valid === 1'b1) begin n++; r = bus.result; end
      end
      checks++;
      if (n != 1 || re_of(r) !== 21'sd0 || im_of(r) !== 21'sd8) begin
         errors++;
         $display("FAIL mac4 got n=%0d re=%0d im=%0d expected n=1 re=0 im=8",
                  n, re_of(r), im_of(r));
      end
      n = 0; r = '0;
      for (int i = 0; i < 6; i++) begin
         if (i < 2) drive(1'b1, 1'b1, 16'h0101, 16'h0101, 2'd2, i == 1);
         else idle();
         if (bus.valid === 1'b1) begin n++; r = bus.result; end
      end
      checks++;
      if (n != 1 || re_of(r) !== 21'sd0 || im_of(r) !== 21'sd4) begin
         errors++;
         $display("FAIL mac2_after_clear got n=%0d re=%0d im=%0d expected n=1 re=0 im=4",
                  n, re_of(r), im_of(r));
      end
   endtask

   // MAC, plain product, conj MAC close: the plain beat must not disturb the acc.
   task automatic test_interleave();
      int n;
      logic [2*RW-1:0] r0, r1;
      n = 0; r0 = '0; r1 = '0;
      for (int i = 0; i < 8; i++) begin
         case (i)
            0: drive(1'b1, 1'b1, 16'h0101, 16'h0101, 2'd2, 1'b0);
            1: drive(1'b1, 1'b1, 16'h0403, 16'hFE01, 2'd0, 1'b0);
            2: drive(1'b1, 1'b1, 16'h0101, 16'h0101, 2'd3, 1'b1);
            default: idle();
         endcase
         if (bus.valid === 1'b1) begin
            if (n == 0) r0 = bus.result; else r1 = bus.result;
            n++;
         end
      end
      checks++;
      if (n != 2) begin
         errors++; $display("FAIL interleave_count got %0d expected 2", n);
      end
      checks++;
      if (re_of(r0) !== 21'sd11 || im_of(r0) !== -21'sd2) begin
         errors++;
         $display("FAIL interleave_plain got re=%0d im=%0d expected re=11 im=-2",
                  re_of(r0), im_of(r0));
      end
      checks++;
      if (re_of(r1) !== 21'sd2 || im_of(r1) !== 21'sd2) begin
         errors++;
         $display("FAIL interleave_mac got re=%0d im=%0d expected re=2 im=2",
                  re_of(r1), im_of(r1));
      end
   endtask

   // Beat k is (k+1) * (2+1j); out_ready low in cycles 4..6 of the stream.
   task automatic test_back_to_back();
      int sent, got;
      logic fire_in, fire_out;
      logic [2*RW-1:0] exp_r;
      sent = 0; got = 0;
      for (int c = 1; c <= 16; c++) begin
         bus.out_ready = !(c >= 4 && c <= 6);
         bus.mode      = 2'd0;
         bus.in_last   = 1'b0;
         bus.b         = 16'h0102;
         bus.a         = {8'h00, 8'(sent + 1)};
         bus.a_valid   = (sent < 6);
         bus.b_valid   = (sent < 6);
         #1;
         if (c >= 4 && c <= 6) begin
            checks++;
            if (bus.in_ready !== 1'b0) begin
               errors++; $display("FAIL stall_in_ready c=%0d got %b expected 0", c, bus.in_ready);
            end
            exp_r = {RW'(1), RW'(2)};
            checks++;
            if (bus.valid !== 1'b1 || bus.result !== exp_r) begin
               errors++;
               $display("FAIL stall_hold c=%0d got valid=%b result=%h expected valid=1 result=%h",
                        c, bus.valid, bus.result, exp_r);
            end
         end
         if (c == 7) begin
            checks++;
            if (bus.in_ready !== 1'b1) begin
               errors++; $display("FAIL release_in_ready got %b expected 1", bus.in_ready);
            end
         end
         fire_in  = bus.a_valid & bus.b_valid & bus.in_ready;
         fire_out = bus.valid & bus.out_ready;
         if (fire_out) begin
            exp_r = {RW'(got + 1), RW'(2 * got + 2)};
            checks++;
            if (got >= 6 || bus.result !== exp_r) begin
               errors++;
               $display("FAIL stream_out idx=%0d got %h expected %h", got, bus.result, exp_r);
            end
            got++;
         end
         @(posedge clk);
         #1;
         if (fire_in) sent++;
      end
      bus.out_ready = 1'b1;
      idle();
      checks++;
      if (sent != 6 || got != 6) begin
         errors++; $display("FAIL stream_count got sent=%0d out=%0d expected 6 and 6", sent, got);
      end
   endtask

   task automatic test_one_operand();
      int n;
      logic [2*RW-1:0] r;
      n = 0; r = '0;
      for (int i = 0; i < 10; i++) begin
         if (i < 3)       drive(1'b1, 1'b0, 16'h0505, 16'h0707, 2'd0, 1'b0);
         else if (i == 3) drive(1'b1, 1'b1, 16'h0002, 16'h0003, 2'd0, 1'b0);
         else             idle();
         if (bus.valid === 1'b1) begin n++; r = bus.result; end
      end
      checks++;
      if (n != 1 || re_of(r) !== 21'sd6 || im_of(r) !== 21'sd0) begin
         errors++;
         $display("FAIL one_operand got n=%0d re=%0d im=%0d expected n=1 re=6 im=0",
                  n, re_of(r), im_of(r));
      end
   endtask

   task automatic test_reset_midgroup();
      int n;
      logic [2*RW-1:0] r;
      drive(1'b1, 1'b1, 16'h0403, 16'hFE01, 2'd0, 1'b0);
      drive(1'b1, 1'b1, 16'h0101, 16'h0101, 2'd2, 1'b0);
      drive(1'b1, 1'b1, 16'h0101, 16'h0101, 2'd2, 1'b0);
      checks++;
      if (bus.valid !== 1'b1) begin
         errors++; $display("FAIL pre_reset_valid got %b expected 1", bus.valid);
      end
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b0;
      rst_n       = 1'b0;
      #1;
      checks++;
      if (bus.valid !== 1'b0 || bus.result !== '0) begin
         errors++;
         $display("FAIL async_reset got valid=%b result=%h expected valid=0 result=0",
                  bus.valid, bus.result);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      n = 0; r = '0;
      for (int i = 0; i < 6; i++) begin
         if (i < 2) drive(1'b1, 1'b1, 16'h0101, 16'h0101, 2'd2, i == 1);
         else idle();
         if (bus.valid === 1'b1) begin n++; r = bus.result; end
      end
      checks++;
      if (n != 1 || re_of(r) !== 21'sd0 || im_of(r) !== 21'sd4) begin
         errors++;
         $display("FAIL post_reset_mac got n=%0d re=%0d im=%0d expected n=1 re=0 im=4",
                  n, re_of(r), im_of(r));
      end
   endtask

   initial begin
      test_reset();
      test_product("mode0_basic", 16'h0403, 16'hFE01, 2'd0, 11, -2);
      test_product("mode1_basic", 16'h0403, 16'hFE01, 2'd1, -5, 10);
      test_product("mode0_minval", 16'h8080, 16'h8080, 2'd0, 0, 32768);
      test_product("mode1_minval", 16'h8080, 16'h8080, 2'd1, 32768, 0);
      test_mac_group();
      test_interleave();
      test_back_to_back();
      test_one_operand();
      test_reset_midgroup();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
